// File: rtl/config_frame_writer_if.sv
// Word stream from the column config controller into a frame writer.
// master drives data/valid; slave (the writer) returns ready.
interface config_frame_writer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/config_frame_writer.sv
// Frame latch write sequencer: header + N data words become a
// setup/strobe/hold sequence on one-hot FrameStrobe lines.
module config_frame_writer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic                       CLK,
  input  logic                       reset,
  config_frame_writer_if.slave       s,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

  localparam logic [7:0] SetupLast  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] StrobeLast = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HoldLast   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] IdxLimit   = 8'(MaxFramesPerCol);

  state_t                     state, nextState;
  logic [7:0]                 phase, nextPhase;
  logic [7:0]                 idx, nextIdx;
  logic [15:0]                remaining, nextRemaining;
  logic                       readyQ, nextReady;
  logic                       accept, setErr, loadData, inRange;
  logic [MaxFramesPerCol-1:0] oneHot, nextStrobe;

  assign accept    = s.s_valid & readyQ;
  assign s.s_ready = readyQ;
  assign busy      = (state != IDLE);
  assign inRange   = (idx < IdxLimit);

  // Per-line decode of the current frame index.
  for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_dec
    assign oneHot[f] = (idx == 8'(f));
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      idx         <= '0;
      remaining   <= '0;
      readyQ      <= 1'b0;
      FrameStrobe <= '0;
      FrameData   <= '0;
      err         <= 1'b0;
    end else begin
      state       <= nextState;
      phase       <= nextPhase;
      idx         <= nextIdx;
      remaining   <= nextRemaining;
      readyQ      <= nextReady;
      FrameStrobe <= nextStrobe;
      if (setErr)   err       <= 1'b1;
      if (loadData) FrameData <= s.s_data;
    end
  end

  always_comb begin
    nextState     = state;
    nextPhase     = phase;
    nextIdx       = idx;
    nextRemaining = remaining;
    setErr        = 1'b0;
    loadData      = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (s.s_data[31:24] != 8'hA5) begin
          setErr = 1'b1;
        end else if (s.s_data[15:0] != 16'd0) begin
          nextIdx       = s.s_data[23:16];
          nextRemaining = s.s_data[15:0];
          nextState     = LOAD;
        end
      end
      LOAD: if (accept) begin
        loadData  = 1'b1;
        nextPhase = '0;
        nextState = SETUP;
      end
      SETUP: begin
        if (phase == SetupLast) begin
          nextPhase = '0;
          nextState = STROBE;
        end else nextPhase = phase + 8'd1;
      end
      STROBE: begin
        if (phase == StrobeLast) begin
          nextPhase = '0;
          nextState = HOLD;
        end else nextPhase = phase + 8'd1;
      end
      HOLD: begin
        if (phase == HoldLast) begin
          nextPhase     = '0;
          // idx saturates so out-of-range frames never alias back into range
          nextIdx       = (idx == 8'hFF) ? idx : idx + 8'd1;
          nextRemaining = remaining - 16'd1;
          nextState     = (remaining == 16'd1) ? IDLE : LOAD;
        end else nextPhase = phase + 8'd1;
      end
      default: nextState = IDLE;
    endcase

    nextReady  = (nextState == IDLE) || (nextState == LOAD);
    nextStrobe = '0;
    if (nextState == STROBE && inRange) nextStrobe = oneHot;
    if (nextState == STROBE && state != STROBE && !inRange) setErr = 1'b1;
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Bench for config_frame_writer: timeline model + directed literal checks.
module tb_config_frame_writer;
  localparam int MF = 20, SU = 1, ST = 2, HO = 1;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  config_frame_writer_if bus();
  logic [31:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic busy, err;

  config_frame_writer #(
    .FrameBitsPerRow(32), .MaxFramesPerCol(MF),
    .SETUP_CYCLES(SU), .STROBE_CYCLES(ST), .HOLD_CYCLES(HO)
  ) dut (
    .CLK(CLK), .reset(reset), .s(bus),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .err(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted data word expands into a timeline of per-cycle
  // expectations (setup, strobe, hold); ready is high whenever none is pending.
  typedef struct { logic [MF-1:0] strobe; logic e; } ent_t;
  ent_t plan[$];
  logic mReady = 0, mBusy = 0, mErr = 0;
  logic [31:0] mData = 0;
  logic [MF-1:0] mStrobe = 0;
  int left = 0, idx = 0;

  initial forever begin
    @(posedge CLK or posedge reset);
    if (reset) begin
      mReady = 0; mBusy = 0; mErr = 0; mData = 0; mStrobe = 0;
      left = 0; idx = 0; plan.delete();
    end else begin
      ent_t e;
      bit inPlan;
      inPlan = 0;
      if (mReady && bus.s_valid) begin
        if (left == 0) begin
          if (bus.s_data[31:24] != 8'hA5) mErr = 1;
          else if (bus.s_data[15:0] != 0) begin
            left = int'(bus.s_data[15:0]);
            idx  = int'(bus.s_data[23:16]);
          end
        end else begin
          mData = bus.s_data;
          for (int i = 0; i < SU; i++) begin e.strobe = '0; e.e = 0; plan.push_back(e); end
          for (int i = 0; i < ST; i++) begin
            e.strobe = (idx < MF) ? (MF'(1) << idx) : '0;
            e.e = (i == 0) && (idx >= MF);
            plan.push_back(e);
          end
          for (int i = 0; i < HO; i++) begin e.strobe = '0; e.e = 0; plan.push_back(e); end
          left--;
          if (idx < 255) idx++;
        end
      end
      if (plan.size() > 0) begin
        e = plan.pop_front();
        mStrobe = e.strobe; mErr = mErr | e.e; mReady = 0; inPlan = 1;
      end else begin
        mStrobe = '0; mReady = 1;
      end
      mBusy = (left > 0) || inPlan;
    end
  end

  always @(negedge CLK) begin
    chk("s_ready", 32'(bus.s_ready), 32'(mReady));
    chk("FrameStrobe", 32'(FrameStrobe), 32'(mStrobe));
    chk("FrameData", FrameData, mData);
    chk("busy", 32'(busy), 32'(mBusy));
    chk("err", 32'(err), 32'(mErr));
  end

  // Observation logs for the literal checks.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  logic [MF-1:0] sLog[$];
  logic [31:0] dLog[$];
  int aLog[$];
  always @(negedge CLK) begin
    if (!reset && FrameStrobe != 0) begin sLog.push_back(FrameStrobe); dLog.push_back(FrameData); end
    if (!reset && bus.s_valid && bus.s_ready) aLog.push_back(cyc);
  end

  task automatic clearLogs();
    sLog.delete(); dLog.delete(); aLog.delete();
  endtask

  task automatic chkLog(input string nm, input int k, input logic [MF-1:0] s, input logic [31:0] d);
    if (k < sLog.size()) begin
      chk({nm, "_strobe"}, 32'(sLog[k]), 32'(s));
      chk({nm, "_data"}, dLog[k], d);
    end else chk({nm, "_missing"}, 32'(sLog.size()), 32'(k + 1));
  endtask

  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 0;
    bus.s_data = w; bus.s_valid = 1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge CLK); ok = bus.s_ready;
      @(posedge CLK);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    @(posedge CLK); #1;
    reset = 1; bus.s_valid = 0;
    repeat (2) @(posedge CLK);
    #1 reset = 0;
    @(posedge CLK); #1;
    clearLogs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_data = 0; bus.s_valid = 0;
    #1 reset = 1;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_strobe", 32'(FrameStrobe), 0);
    chk("rst_data", FrameData, 0);
    chk("rst_ready", 32'(bus.s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge CLK); #1 reset = 0;
    @(posedge CLK); #1;
    chk("post_rst_ready", 32'(bus.s_ready), 1);
    clearLogs();

    // two frames, valid held high
    send(32'hA500_0002); send(32'hDEADBEEF); send(32'h12345678); idle(6);
    chk("t1_count", 32'(sLog.size()), 4);
    chkLog("t1_0", 0, 20'h00001, 32'hDEADBEEF);
    chkLog("t1_1", 1, 20'h00001, 32'hDEADBEEF);
    chkLog("t1_2", 2, 20'h00002, 32'h12345678);
    chkLog("t1_3", 3, 20'h00002, 32'h12345678);
    if (aLog.size() == 3) begin
      chk("t1_hdr_gap", 32'(aLog[1] - aLog[0]), 1);
      chk("t1_frame_gap", 32'(aLog[2] - aLog[1]), 5);
    end else chk("t1_accepts", 32'(aLog.size()), 3);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy", 32'(busy), 0);

    // bad sync, then a good header with err sticky
    clearLogs();
    send(32'h5A00_0001); idle(3);
    chk("t2_err", 32'(err), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_nostrobe", 32'(sLog.size()), 0);
    send(32'hA501_0001); send(32'h0000CAFE); idle(6);
    chk("t2_count", 32'(sLog.size()), 2);
    chkLog("t2_0", 0, 20'h00002, 32'h0000CAFE);
    chk("t2_err_sticky", 32'(err), 1);

    // last in-range frame then out of range
    doReset();
    send(32'hA513_0002); send(32'h11111111); send(32'h22222222); idle(6);
    chk("t3_count", 32'(sLog.size()), 2);
    chkLog("t3_0", 0, 20'h80000, 32'h11111111);
    chk("t3_err", 32'(err), 1);
    chk("t3_busy", 32'(busy), 0);

    // N = 0 header; next word is a header
    doReset();
    send(32'hA500_0000); idle(2);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_nostrobe", 32'(sLog.size()), 0);
    send(32'hA504_0001); send(32'h0000BEEF); idle(6);
    chkLog("t4_0", 0, 20'h00010, 32'h0000BEEF);
    chk("t4_err", 32'(err), 0);

    // gap in LOAD
    clearLogs();
    send(32'hA502_0002); send(32'hAAAA0001); idle(7);
    chk("t5_gap_count", 32'(sLog.size()), 2);
    chk("t5_gap_data", FrameData, 32'hAAAA0001);
    chk("t5_gap_strobe", 32'(FrameStrobe), 0);
    chk("t5_gap_busy", 32'(busy), 1);
    send(32'hAAAA0002); idle(6);
    chk("t5_count", 32'(sLog.size()), 4);
    chkLog("t5_0", 0, 20'h00004, 32'hAAAA0001);
    chkLog("t5_2", 2, 20'h00008, 32'hAAAA0002);
    chk("t5_busy", 32'(busy), 0);

    // async reset during frame 3 strobe
    clearLogs();
    send(32'hA500_0004);
    send(32'h00000000); send(32'h00000001); send(32'h00000002); send(32'h00000003);
    bus.s_valid = 0;
    @(posedge CLK); #2;
    chk("t6_strobe_pre", 32'(FrameStrobe), 32'h00008);
    chk("t6_data_pre", FrameData, 32'h00000003);
    reset = 1; #1;
    chk("t6_strobe_async", 32'(FrameStrobe), 0);
    chk("t6_data_async", FrameData, 0);
    chk("t6_busy_async", 32'(busy), 0);
    @(posedge CLK); #1 reset = 0;
    @(posedge CLK); #1;
    chk("t6_ready", 32'(bus.s_ready), 1);
    chk("t6_err", 32'(err), 0);
    chk("t6_busy", 32'(busy), 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Write-side sequencer for a tile's configuration frame latches.
- Accepts a stream of 32-bit words over a valid/ready handshake: one header word, then N frame data words.
- Drives FrameData and a one-hot FrameStrobe per frame, with setup/strobe/hold spacing that level-sensitive latches tolerate.
- Sits between the column config controller and the tile ConfigMem instances of one column.

Parameters:
FrameBitsPerRow, 32, width of FrameData and of each input word (fixed 32 in this block)
MaxFramesPerCol, 20, number of FrameStrobe lines; valid frame indices 0..MaxFramesPerCol-1
SETUP_CYCLES, 1, cycles FrameData is stable before strobe rises (>=1)
STROBE_CYCLES, 2, cycles strobe is held high (>=1)
HOLD_CYCLES, 1, cycles FrameData is held after strobe falls (>=1)

Ports:
CLK  in  1  single clock
reset  in  1  asynchronous, active-high reset
s_data  in  32  header or frame data word
s_valid  in  1  s_data valid
s_ready  out  1  word accepted on a CLK edge with s_valid&s_ready
FrameData  out  FrameBitsPerRow  data to frame latches
FrameStrobe  out  MaxFramesPerCol  one-hot latch enable; all-zero when idle
busy  out  1  high in any state except IDLE
err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async) forces the following immediately, including mid-strobe: FrameStrobe=0, FrameData=0, s_ready=0, busy=0, err=0, state=IDLE, counters=0. First cycle after reset release: s_ready=1.
- Header format: [31:24] sync = 8'hA5; [23:16] start frame index F; [15:0] frame count N.
- States: IDLE, LOAD, SETUP, STROBE, HOLD.
- IDLE: s_ready=1. On an accepted word:
  - sync != A5: discard word, set err, stay IDLE.
  - N==0: stay IDLE.
  - Otherwise: latch idx=F, remaining=N, go to LOAD.
- LOAD: s_ready=1. On an accepted word: FrameData<=s_data on that edge, go to SETUP. Without s_valid: wait indefinitely; strobe stays 0.
- SETUP: s_ready=0. Lasts SETUP_CYCLES cycles, then go to STROBE.
- STROBE: lasts STROBE_CYCLES cycles.
  - idx < MaxFramesPerCol: FrameStrobe[idx]=1, all other bits 0.
  - idx >= MaxFramesPerCol: FrameStrobe stays all-zero, err set.
- HOLD: FrameStrobe=0, FrameData unchanged, lasts HOLD_CYCLES cycles. At exit: idx++, remaining--; remaining reaches 0 -> IDLE, else -> LOAD.
- FrameStrobe is registered; it never has more than one bit high.
- FrameData changes only on LOAD acceptance (and reset); it is held across IDLE.
- Minimum per-frame period: 1 + SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES = 5 cycles at defaults.
- idx is 8-bit and saturates at 255 (no wrap). Out-of-range frames are consumed but never strobed.
- s_valid while s_ready=0 is held off by the source (standard handshake); the block ignores s_data while s_ready=0.
- busy=1 from the edge accepting a header with N>0 until the HOLD->IDLE transition.

Test Plan:
- Header 32'hA5_00_0002, then words 32'hDEADBEEF and 32'h12345678, s_valid always high -> FrameData=DEADBEEF one cycle before FrameStrobe=20'h00001 (2 cycles); then 12345678 with FrameStrobe=20'h00002; accepts 5 cycles apart; back to IDLE, err=0.
- Header 32'h5A_00_0001 -> word discarded, err=1, state IDLE, FrameStrobe never nonzero; a following valid header still processes normally with err remaining 1.
- Header 32'hA5_13_0002 (F=19), two data words -> FrameStrobe=1<<19 for the first word; no strobe for the second (idx 20); err=1; returns to IDLE.
- Header with N=0 -> busy stays 0, no strobe; the next word is treated as a header.
- Data word gaps: s_valid low for 7 cycles in LOAD -> FrameStrobe stays 0 and FrameData holds its previous value; sequence resumes correctly once s_valid rises.
- Assert reset during STROBE of frame 3 -> FrameStrobe=0 and FrameData=0 in the same cycle (async); after release, state IDLE, s_ready=1, err=0.
